qdiv_hs: RTL and testbench

QDIV_HS -- requirements
Module: qdiv_hs

---
 rtl/qmath_pkg.sv | 22 ++
 rtl/qdiv_step.sv | 35 +++
 rtl/qdiv_hs.sv | 166 ++++++++++++++++
 tb/tb_qdiv_hs.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/qmath_pkg.sv
// ---------------------------------------------------------------------------
// qmath_pkg
// Shared definitions for the fixed-point math blocks.
//   qdiv_state_e : handshake divider FSM state encoding
//   iter_cnt_w() : width of the divider iteration counter for a given N/Q.
//                  It is sized for N+Q so the extra guard-bit iteration used
//                  when rounding still fits.
// ---------------------------------------------------------------------------
package qmath_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FINAL = 2'd2,
        ST_HOLD  = 2'd3
    } qdiv_state_e;

    function automatic int iter_cnt_w(input int n, input int q);
        return $clog2(n + q + 1);
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// ---------------------------------------------------------------------------
// qdiv_step
// One restoring shift-subtract division step (purely combinational).
//   rem_i [N-2:0]   : partial remainder, always < divisor
//   dq_i  [DQW-1:0] : shift register holding the remaining dividend bits at
//                     the top and the quotient bits produced so far at the bottom
//   dvs_i [N-2:0]   : divisor magnitude
//   rem_o, dq_o     : state after this step (new quotient bit enters at LSB)
// ---------------------------------------------------------------------------
module qdiv_step #(
    parameter int N   = 32,
    parameter int DQW = 46
) (
    input  logic [N-2:0]   rem_i,
    input  logic [DQW-1:0] dq_i,
    input  logic [N-2:0]   dvs_i,
    output logic [N-2:0]   rem_o,
    output logic [DQW-1:0] dq_o
);

    logic [N-1:0] rem_sh;
    logic [N-1:0] diff;
    logic         ge;

    always_comb begin
        rem_sh = {rem_i, dq_i[DQW-1]};
        diff   = rem_sh - {1'b0, dvs_i};
        // rem_i < divisor, so rem_sh < 2*divisor and |diff| < 2^(N-1):
        // the top bit of diff is a reliable borrow flag.
        ge     = ~diff[N-1];
        rem_o  = ge ? diff[N-2:0] : rem_sh[N-2:0];
        dq_o   = {dq_i[DQW-2:0], ge};
    end

endmodule

// File: rtl/qdiv_hs.sv
// ---------------------------------------------------------------------------
// qdiv_hs
// Sequential sign-magnitude fixed-point divider with valid/ready handshakes.
// One quotient bit per cycle via qdiv_step; optional rounding and saturation.
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_valid / o_ready       : operand handshake (accepted only in IDLE)
//   i_dividend, i_divisor   : sign-magnitude Q(N-1-Q).Q operands
//   o_valid / i_ready       : result handshake (o_valid only in HOLD)
//   o_quotient              : sign-magnitude quotient
//   o_overflow, o_dbz       : overflow / divide-by-zero flags
// ---------------------------------------------------------------------------
module qdiv_hs
    import qmath_pkg::*;
#(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int SAT   = 1,
    parameter int ROUND = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_quotient,
    output logic         o_overflow,
    output logic         o_dbz
);

    localparam int MW   = N - 1;              // magnitude width
    localparam int ITER = N - 1 + Q + ROUND;  // quotient bits incl. guard bit
    localparam int RW   = ITER + 1;           // room for the rounding carry
    localparam int CW   = iter_cnt_w(N, Q);

    qdiv_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   rem_q, rem_d;
    logic [ITER-1:0] dq_q, dq_d;
    logic [MW-1:0]   dvs_q, dvs_d;
    logic            sign_q, sign_d;
    logic            dbz_q, dbz_d;
    logic [N-1:0]    quo_q, quo_d;
    logic            ovf_q, ovf_d;
    logic            dbz_out_q, dbz_out_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;

    logic [MW-1:0]   step_rem;
    logic [ITER-1:0] step_dq;

    logic [RW-1:0]   q_ext;
    logic [RW-1:0]   rnd;
    logic            fin_ovf;
    logic [MW-1:0]   mag;

    qdiv_step #(.N(N), .DQW(ITER)) u_step (
        .rem_i (rem_q),
        .dq_i  (dq_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dq_o  (step_dq)
    );

    // Result shaping for FINAL. With ROUND the raw quotient carries one extra
    // fraction bit; dropping it and adding it back gives ties-away-from-zero
    // on the magnitude.
    always_comb begin
        q_ext   = {1'b0, dq_q};
        rnd     = (q_ext >> ROUND) + RW'((ROUND != 0) ? dq_q[0] : 1'b0);
        fin_ovf = |rnd[RW-1:MW];
        if (dbz_q || (fin_ovf && (SAT != 0)))
            mag = '1;
        else
            mag = rnd[MW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        dvs_d     = dvs_q;
        sign_d    = sign_q;
        dbz_d     = dbz_q;
        quo_d     = quo_q;
        ovf_d     = ovf_q;
        dbz_out_d = dbz_out_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    sign_d = i_dividend[N-1] ^ i_divisor[N-1];
                    dvs_d  = i_divisor[N-2:0];
                    dq_d   = {i_dividend[N-2:0], {(Q + ROUND){1'b0}}};
                    rem_d  = '0;
                    cnt_d  = CW'(ITER);
                    dbz_d  = (i_divisor[N-2:0] == '0);
                    state_d = (i_divisor[N-2:0] == '0) ? ST_FINAL : ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dq_d  = step_dq;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1))
                    state_d = ST_FINAL;
            end
            ST_FINAL: begin
                // Zero magnitude never carries a sign.
                quo_d     = {sign_q & (|mag), mag};
                ovf_d     = dbz_q | fin_ovf;
                dbz_out_d = dbz_q;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flags are registered copies of the next state decode.
        valid_d = (state_d == ST_HOLD);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            sign_q    <= 1'b0;
            dbz_q     <= 1'b0;
            quo_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_out_q <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            dvs_q     <= dvs_d;
            sign_q    <= sign_d;
            dbz_q     <= dbz_d;
            quo_q     <= quo_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_out_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_quotient = quo_q;
    assign o_overflow = ovf_q;
    assign o_dbz      = dbz_out_q;

endmodule

// File: tb/tb_qdiv_hs.sv
// ---------------------------------------------------------------------------
// tb_qdiv_hs
// Three divider instances share stimulus:
//   d0: SAT=1 ROUND=0, d1: SAT=0 ROUND=0, d2: SAT=1 ROUND=1  (all N=32, Q=15)
// Latency is counted in edges after the accepting edge until o_valid is seen:
// ITER+1 (47, or 48 with ROUND) for a normal divide, 1 for divide-by-zero.
// ---------------------------------------------------------------------------
module tb_qdiv_hs;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor  = '0;

    logic [2:0]       o_ready_v, o_valid_v, ovf_v, dbz_v;
    logic [2:0][31:0] quo_v;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    qdiv_hs #(.Q(15), .N(32), .SAT(1), .ROUND(0)) u_d0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_v[0]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid_v[0]),
        .i_ready(i_ready), .o_quotient(quo_v[0]), .o_overflow(ovf_v[0]), .o_dbz(dbz_v[0]));

    qdiv_hs #(.Q(15), .N(32), .SAT(0), .ROUND(0)) u_d1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_v[1]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid_v[1]),
        .i_ready(i_ready), .o_quotient(quo_v[1]), .o_overflow(ovf_v[1]), .o_dbz(dbz_v[1]));

    qdiv_hs #(.Q(15), .N(32), .SAT(1), .ROUND(1)) u_d2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_v[2]),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid_v[2]),
        .i_ready(i_ready), .o_quotient(quo_v[2]), .o_overflow(ovf_v[2]), .o_dbz(dbz_v[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operand pair to all instances, collect each result, check it,
    // then complete the result handshake. Called at #1 after an edge.
    // eq/eovf/edbz are packed {d2, d1, d0}.
    task automatic run_op(input int vi, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0][31:0] eq, input logic [2:0] eovf,
                          input logic [2:0] edbz, input bit hold_test);
        logic [2:0]       seen;
        logic [2:0][31:0] q_cap;
        logic [2:0]       ovf_cap, dbz_cap;
        int               lat [3];
        int               exp_lat;
        bit               stable;
        seen = '0;
        q_cap = '0;
        ovf_cap = '0;
        dbz_cap = '0;
        for (int k = 0; k < 3; k++) lat[k] = 0;

        i_valid = 1'b1; i_dividend = a; i_divisor = b;
        @(posedge i_clk); #1;
        // Junk on the inputs while busy must be ignored.
        i_valid = 1'b0; i_dividend = 32'hDEAD_BEEF; i_divisor = 32'h0;
        chk($sformatf("v%0d ready_low", vi), o_ready_v, 3'b000);

        for (int c = 1; c <= 200; c++) begin
            @(posedge i_clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (o_valid_v[k] && !seen[k]) begin
                    seen[k] = 1'b1; lat[k] = c;
                    q_cap[k] = quo_v[k]; ovf_cap[k] = ovf_v[k]; dbz_cap[k] = dbz_v[k];
                end
            end
            if (seen == 3'b111) break;
        end
        chk($sformatf("v%0d all_valid", vi), seen, 3'b111);

        for (int k = 0; k < 3; k++) begin
            exp_lat = edbz[k] ? 1 : ((k == 2) ? 48 : 47);
            chk($sformatf("v%0d d%0d latency", vi, k), lat[k], exp_lat);
            chk($sformatf("v%0d d%0d quotient", vi, k), q_cap[k], eq[k]);
            chk($sformatf("v%0d d%0d overflow", vi, k), ovf_cap[k], eovf[k]);
            chk($sformatf("v%0d d%0d dbz", vi, k), dbz_cap[k], edbz[k]);
        end

        if (hold_test) begin
            stable = 1'b1;
            repeat (20) begin
                @(posedge i_clk); #1;
                if (quo_v !== eq || o_valid_v !== 3'b111 || o_ready_v !== 3'b000)
                    stable = 1'b0;
            end
            chk($sformatf("v%0d backpressure_stable", vi), stable, 1'b1);
        end

        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk($sformatf("v%0d valid_dropped", vi), o_valid_v, 3'b000);
        chk($sformatf("v%0d ready_back", vi), o_ready_v, 3'b111);
        chk($sformatf("v%0d quotient_held", vi), quo_v, eq);
    endtask

    initial begin
        bit seen_valid;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst ready", o_ready_v, 3'b111);
        chk("rst valid", o_valid_v, 3'b000);
        chk("rst quotient", quo_v, '0);
        chk("rst overflow", ovf_v, 3'b000);
        chk("rst dbz", dbz_v, 3'b000);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // 1.5 / 0.5 = 3.0, with backpressure hold
        run_op(1, 32'h0000C000, 32'h00004000,
               {32'h00018000, 32'h00018000, 32'h00018000}, 3'b000, 3'b000, 1'b1);
        // -1.5 / 0.5 = -3.0
        run_op(2, 32'h8000C000, 32'h00004000,
               {32'h80018000, 32'h80018000, 32'h80018000}, 3'b000, 3'b000, 1'b0);
        // -0 / 0.5 -> +0
        run_op(3, 32'h80000000, 32'h00004000,
               {32'h00000000, 32'h00000000, 32'h00000000}, 3'b000, 3'b000, 1'b0);
        // divide by -0: max magnitude, negative, regardless of SAT
        run_op(4, 32'h00010000, 32'h80000000,
               {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 3'b111, 3'b111, 1'b0);
        // 32768 / 0.5 overflows: clamp vs wrap (low 31 bits zero, sign cleared)
        run_op(5, 32'h40000000, 32'h00004000,
               {32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF}, 3'b111, 3'b000, 1'b0);
        // 1 / 3: truncate vs round
        run_op(6, 32'h00008000, 32'h00018000,
               {32'h00002AAB, 32'h00002AAA, 32'h00002AAA}, 3'b000, 3'b000, 1'b0);
        // -1 / 3
        run_op(7, 32'h80008000, 32'h00018000,
               {32'h80002AAB, 32'h80002AAA, 32'h80002AAA}, 3'b000, 3'b000, 1'b0);
        // exact tie 2^-15 / 2 = 2^-16: rounds away from zero to 1 LSB
        run_op(8, 32'h80000001, 32'h00010000,
               {32'h80000001, 32'h00000000, 32'h00000000}, 3'b000, 3'b000, 1'b0);
        // leave a nonzero result registered before the reset test
        run_op(9, 32'h0000C000, 32'h00004000,
               {32'h00018000, 32'h00018000, 32'h00018000}, 3'b000, 3'b000, 1'b0);

        // Reset mid-CALC, with i_valid asserted on the reset edges
        i_valid = 1'b1; i_dividend = 32'h00008000; i_divisor = 32'h00018000;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        chk("midcalc busy", o_ready_v, 3'b000);
        i_rst_n = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        chk("rst2 ready", o_ready_v, 3'b111);
        chk("rst2 valid", o_valid_v, 3'b000);
        chk("rst2 quotient", quo_v, '0);
        @(posedge i_clk); #1;
        chk("rst2 dominates valid", o_ready_v, 3'b111);
        i_rst_n = 1'b1; i_valid = 1'b0;
        seen_valid = 1'b0;
        repeat (60) begin
            @(posedge i_clk); #1;
            if (o_valid_v != 3'b000) seen_valid = 1'b1;
        end
        chk("rst2 no result", seen_valid, 1'b0);
        chk("rst2 idle after", o_ready_v, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
